// File: rtl/sc_modcounter.sv
// Up/down modulo counter with prescaled stepping, load clamp, and registered carry/borrow pulses.
// Wraps or saturates at the bounds; every output is driven straight from a register.
module sc_modcounter #(
    parameter int              MODCOUNTER_DATAWIDTH = 8,
    parameter longint unsigned MODCOUNTER_MODULUS   = 64'd1 << MODCOUNTER_DATAWIDTH,
    parameter bit              MODCOUNTER_SATURATE  = 1'b0,
    parameter int              MODCOUNTER_PRESCALE  = 1
) (
    input  logic                            SC_MODCOUNTER_CLOCK_50,
    input  logic                            SC_MODCOUNTER_RESET_InLow,
    input  logic                            SC_MODCOUNTER_clear_InLow,
    input  logic                            SC_MODCOUNTER_load_InLow,
    input  logic [MODCOUNTER_DATAWIDTH-1:0] SC_MODCOUNTER_data_InBUS,
    input  logic                            SC_MODCOUNTER_upcount_InLow,
    input  logic                            SC_MODCOUNTER_downcount_InLow,
    output logic [MODCOUNTER_DATAWIDTH-1:0] SC_MODCOUNTER_data_OutBUS,
    output logic                            SC_MODCOUNTER_carry_OutHigh,
    output logic                            SC_MODCOUNTER_borrow_OutHigh
);

    localparam int            W        = MODCOUNTER_DATAWIDTH;
    localparam logic [W-1:0]  MAX_VAL  = W'(MODCOUNTER_MODULUS - 64'd1);
    localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [15:0]   PRE_LAST = 16'(MODCOUNTER_PRESCALE - 1);

    logic [W-1:0] count_p1;
    logic [15:0]  prescale_p1;
    logic         carry_p1;
    logic         borrow_p1;

    logic upReq;
    logic downReq;
    logic moving;
    logic stepNow;

    function automatic logic [W-1:0] stepUp(input logic [W-1:0] v);
        if (v == MAX_VAL)
            return MODCOUNTER_SATURATE ? MAX_VAL : '0;
        return v + ONE;
    endfunction

    function automatic logic [W-1:0] stepDown(input logic [W-1:0] v);
        if (v == '0)
            return MODCOUNTER_SATURATE ? '0 : MAX_VAL;
        return v - ONE;
    endfunction

    function automatic logic [W-1:0] clampLoad(input logic [W-1:0] d);
        if (64'(d) >= MODCOUNTER_MODULUS)
            return MAX_VAL;
        return d;
    endfunction

    // Direction decode: exactly one request asserted, otherwise idle
    always_comb begin
        upReq   = !SC_MODCOUNTER_upcount_InLow && SC_MODCOUNTER_downcount_InLow;
        downReq = SC_MODCOUNTER_upcount_InLow && !SC_MODCOUNTER_downcount_InLow;
        moving  = upReq || downReq;
        stepNow = moving && (prescale_p1 == PRE_LAST);
    end

    // Register stage: count, prescaler and the single-cycle carry/borrow pulses
    always_ff @(posedge SC_MODCOUNTER_CLOCK_50 or negedge SC_MODCOUNTER_RESET_InLow) begin
        if (!SC_MODCOUNTER_RESET_InLow) begin
            count_p1    <= '0;
            prescale_p1 <= '0;
            carry_p1    <= 1'b0;
            borrow_p1   <= 1'b0;
        end else begin
            carry_p1  <= 1'b0;
            borrow_p1 <= 1'b0;
            if (!SC_MODCOUNTER_clear_InLow) begin
                count_p1    <= '0;
                prescale_p1 <= '0;
            end else if (!SC_MODCOUNTER_load_InLow) begin
                count_p1    <= clampLoad(SC_MODCOUNTER_data_InBUS);
                prescale_p1 <= '0;
            end else if (moving) begin
                prescale_p1 <= stepNow ? 16'd0 : prescale_p1 + 16'd1;
                if (stepNow) begin
                    if (upReq) begin
                        count_p1 <= stepUp(count_p1);
                        carry_p1 <= (count_p1 == MAX_VAL);
                    end else begin
                        count_p1  <= stepDown(count_p1);
                        borrow_p1 <= (count_p1 == '0);
                    end
                end
            end
        end
    end

    assign SC_MODCOUNTER_data_OutBUS    = count_p1;
    assign SC_MODCOUNTER_carry_OutHigh  = carry_p1;
    assign SC_MODCOUNTER_borrow_OutHigh = borrow_p1;

endmodule

// File: tb/tb_sc_modcounter.sv
// Bench for sc_modcounter: three instances (wrap, saturate, prescale-3) on shared inputs,
// checked against directed tables, hand sequences and an arithmetic reference model.
module tb_sc_modcounter;

    logic       clk = 1'b0;
    logic       rstN, clrN, ldN, upN, dnN;
    logic [3:0] dIn;
    logic [3:0] q   [3];
    logic       car [3];
    logic       bor [3];

    int total = 0;
    int bad   = 0;

    int mMod [3];
    int mSat [3];
    int mPre [3];
    int mCnt [3];
    int mPc  [3];
    int mCar [3];
    int mBor [3];

    always #5 clk = ~clk;

    sc_modcounter #(.MODCOUNTER_DATAWIDTH(4), .MODCOUNTER_MODULUS(10),
                    .MODCOUNTER_SATURATE(1'b0), .MODCOUNTER_PRESCALE(1)) dutWrap (
        .SC_MODCOUNTER_CLOCK_50(clk), .SC_MODCOUNTER_RESET_InLow(rstN),
        .SC_MODCOUNTER_clear_InLow(clrN), .SC_MODCOUNTER_load_InLow(ldN),
        .SC_MODCOUNTER_data_InBUS(dIn), .SC_MODCOUNTER_upcount_InLow(upN),
        .SC_MODCOUNTER_downcount_InLow(dnN), .SC_MODCOUNTER_data_OutBUS(q[0]),
        .SC_MODCOUNTER_carry_OutHigh(car[0]), .SC_MODCOUNTER_borrow_OutHigh(bor[0]));

    sc_modcounter #(.MODCOUNTER_DATAWIDTH(4), .MODCOUNTER_MODULUS(10),
                    .MODCOUNTER_SATURATE(1'b1), .MODCOUNTER_PRESCALE(1)) dutSat (
        .SC_MODCOUNTER_CLOCK_50(clk), .SC_MODCOUNTER_RESET_InLow(rstN),
        .SC_MODCOUNTER_clear_InLow(clrN), .SC_MODCOUNTER_load_InLow(ldN),
        .SC_MODCOUNTER_data_InBUS(dIn), .SC_MODCOUNTER_upcount_InLow(upN),
        .SC_MODCOUNTER_downcount_InLow(dnN), .SC_MODCOUNTER_data_OutBUS(q[1]),
        .SC_MODCOUNTER_carry_OutHigh(car[1]), .SC_MODCOUNTER_borrow_OutHigh(bor[1]));

    sc_modcounter #(.MODCOUNTER_DATAWIDTH(4), .MODCOUNTER_MODULUS(10),
                    .MODCOUNTER_SATURATE(1'b0), .MODCOUNTER_PRESCALE(3)) dutPre (
        .SC_MODCOUNTER_CLOCK_50(clk), .SC_MODCOUNTER_RESET_InLow(rstN),
        .SC_MODCOUNTER_clear_InLow(clrN), .SC_MODCOUNTER_load_InLow(ldN),
        .SC_MODCOUNTER_data_InBUS(dIn), .SC_MODCOUNTER_upcount_InLow(upN),
        .SC_MODCOUNTER_downcount_InLow(dnN), .SC_MODCOUNTER_data_OutBUS(q[2]),
        .SC_MODCOUNTER_carry_OutHigh(car[2]), .SC_MODCOUNTER_borrow_OutHigh(bor[2]));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic setIn(input bit clr, input bit ld, input bit up, input bit dn, input logic [3:0] d);
        clrN = !clr;
        ldN  = !ld;
        upN  = !up;
        dnN  = !dn;
        dIn  = d;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mCnt[i] = 0; mPc[i] = 0; mCar[i] = 0; mBor[i] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, computed with plain modular arithmetic
    task automatic modelEdge();
        bit clr, ld, up, dn;
        clr = !clrN; ld = !ldN; up = !upN && dnN; dn = upN && !dnN;
        for (int i = 0; i < 3; i++) begin
            mCar[i] = 0; mBor[i] = 0;
            if (clr) begin
                mCnt[i] = 0; mPc[i] = 0;
            end else if (ld) begin
                mCnt[i] = (int'(dIn) >= mMod[i]) ? mMod[i] - 1 : int'(dIn);
                mPc[i]  = 0;
            end else if (up || dn) begin
                if (mPc[i] == mPre[i] - 1) begin
                    mPc[i] = 0;
                    if (up) begin
                        mCar[i] = (mCnt[i] == mMod[i] - 1);
                        mCnt[i] = mSat[i] ? ((mCnt[i] + 1 > mMod[i] - 1) ? mMod[i] - 1 : mCnt[i] + 1)
                                          : (mCnt[i] + 1) % mMod[i];
                    end else begin
                        mBor[i] = (mCnt[i] == 0);
                        mCnt[i] = mSat[i] ? ((mCnt[i] == 0) ? 0 : mCnt[i] - 1)
                                          : (mCnt[i] + mMod[i] - 1) % mMod[i];
                    end
                end else begin
                    mPc[i] = mPc[i] + 1;
                end
            end
        end
    endtask

    task automatic compareModel();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_q%0d", i), q[i], mCnt[i]);
            chk($sformatf("model_carry%0d", i), car[i], mCar[i]);
            chk($sformatf("model_borrow%0d", i), bor[i], mBor[i]);
        end
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        #1;
        compareModel();
    endtask

    typedef struct {
        bit         clr, ld, up, dn;
        logic [3:0] data;
        int         expQ;
        bit         expC, expB;
    } vec_t;

    vec_t tbl [20];
    int   preExp [11];

    initial begin
        mMod = '{10, 10, 10};
        mSat = '{0, 1, 0};
        mPre = '{1, 1, 3};

        for (int k = 0; k < 12; k++)
            tbl[k] = '{0, 0, 1, 0, 4'd0, (k + 1) % 10, (k == 9), 0};
        tbl[12] = '{1, 1, 1, 0, 4'd5,  0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 4'hF,  9, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 4'd0,  9, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 4'd0,  9, 0, 0};
        tbl[16] = '{0, 0, 1, 0, 4'd0,  0, 1, 0};
        tbl[17] = '{0, 0, 0, 1, 4'd0,  9, 0, 1};
        tbl[18] = '{0, 0, 0, 1, 4'd0,  8, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 4'd3,  3, 0, 0};

        preExp = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

        rstN = 1'b0;
        setIn(0, 0, 0, 0, 4'd0);
        modelReset();
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_q", q[i], 0);
            chk("reset_carry", car[i], 0);
            chk("reset_borrow", bor[i], 0);
        end
        rstN = 1'b1;

        // Directed table on the wrapping instance
        for (int i = 0; i < 20; i++) begin
            setIn(tbl[i].clr, tbl[i].ld, tbl[i].up, tbl[i].dn, tbl[i].data);
            cycle();
            chk($sformatf("tbl%0d_q", i), q[0], tbl[i].expQ);
            chk($sformatf("tbl%0d_carry", i), car[0], tbl[i].expC);
            chk($sformatf("tbl%0d_borrow", i), bor[0], tbl[i].expB);
        end

        // Saturating down from 2: 1,0,0,0 with borrow on the two steps taken at 0
        setIn(0, 1, 0, 0, 4'd2);
        cycle();
        for (int k = 0; k < 4; k++) begin
            setIn(0, 0, 0, 1, 4'd0);
            cycle();
            chk($sformatf("sat%0d_q", k), q[1], (k == 0) ? 1 : 0);
            chk($sformatf("sat%0d_borrow", k), bor[1], (k >= 2) ? 1 : 0);
        end

        // Prescale 3: up 9 edges from 0 steps on edges 3,6,9
        setIn(1, 0, 0, 0, 4'd0);
        cycle();
        for (int k = 1; k <= 9; k++) begin
            setIn(0, 0, 1, 0, 4'd0);
            cycle();
            chk($sformatf("pre_edge%0d", k), q[2], k / 3);
        end

        // Same run with two idle edges after the fourth up edge
        setIn(1, 0, 0, 0, 4'd0);
        cycle();
        for (int k = 0; k < 11; k++) begin
            if (k == 4 || k == 5) setIn(0, 0, 0, 0, 4'd0);
            else                  setIn(0, 0, 1, 0, 4'd0);
            cycle();
            chk($sformatf("preidle_edge%0d", k + 1), q[2], preExp[k]);
        end

        // Async reset between edges at count 7, with the prescaled instance mid-prescale
        setIn(0, 1, 0, 0, 4'd6);
        cycle();
        setIn(0, 0, 1, 0, 4'd0);
        cycle();
        chk("prereset_q", q[0], 7);
        setIn(0, 0, 0, 0, 4'd0);
        #3;
        rstN = 1'b0;
        #1;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            chk("asyncreset_q", q[i], 0);
            chk("asyncreset_carry", car[i], 0);
        end
        #1;
        rstN = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            setIn(0, 0, 1, 0, 4'd0);
            cycle();
            chk($sformatf("postreset_wrap%0d", k), q[0], k);
            chk($sformatf("postreset_pre%0d", k), q[2], (k == 3) ? 1 : 0);
        end

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            setIn(($urandom_range(15, 0) == 0), ($urandom_range(7, 0) == 0),
                  $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  4'($urandom_range(15, 0)));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_modcounter.md
SC_MODCOUNTER -- requirements
Module: sc_modcounter

Interface
REQ-001 SHALL have parameter MODCOUNTER_DATAWIDTH, default 8: counter width W in bits, legal range 2..32.
REQ-002 SHALL have parameter MODCOUNTER_MODULUS, default 2^W: count range 0..MODULUS-1, legal range 2..2^W.
REQ-003 SHALL have parameter MODCOUNTER_SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 SHALL have parameter MODCOUNTER_PRESCALE, default 1: clock cycles per count step, legal range 1..65535.
REQ-005 SHALL have port SC_MODCOUNTER_CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port SC_MODCOUNTER_RESET_InLow, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port SC_MODCOUNTER_clear_InLow, input, 1 bit: synchronous clear, active-low.
REQ-008 SHALL have port SC_MODCOUNTER_load_InLow, input, 1 bit: synchronous parallel load, active-low.
REQ-009 SHALL have port SC_MODCOUNTER_data_InBUS, input, W bits: load value.
REQ-010 SHALL have port SC_MODCOUNTER_upcount_InLow, input, 1 bit: count-up request, active-low.
REQ-011 SHALL have port SC_MODCOUNTER_downcount_InLow, input, 1 bit: count-down request, active-low.
REQ-012 SHALL have port SC_MODCOUNTER_data_OutBUS, output, W bits: registered count value.
REQ-013 SHALL have port SC_MODCOUNTER_carry_OutHigh, output, 1 bit: one-cycle pulse on an up-step taken at MODULUS-1.
REQ-014 SHALL have port SC_MODCOUNTER_borrow_OutHigh, output, 1 bit: one-cycle pulse on a down-step taken at 0.

Function
REQ-015 SHALL apply priority per clock edge: clear > load > count > hold.
REQ-016 SHALL set count to 0, zero the prescaler and drive carry/borrow 0 on the next edge when clear_InLow=0.
REQ-017 SHALL set count to data_InBUS on load_InLow=0 (clear inactive), clamping any load value >= MODULUS to MODULUS-1; load also zeroes the prescaler.
REQ-018 SHALL treat direction as up when exactly upcount_InLow=0, down when exactly downcount_InLow=0, and idle when both or neither are asserted.
REQ-019 SHALL advance the prescaler (0..PRESCALE-1, wrapping) on each edge while direction is up or down, and hold it while idle.
REQ-020 SHALL take a count step only on an edge where direction is non-idle and the prescaler equals PRESCALE-1; with PRESCALE=1 that is every non-idle edge.
REQ-021 SHALL on an up-step compute count+1, except at count=MODULUS-1, where the result is 0 (SATURATE=0) or stays MODULUS-1 (SATURATE=1).
REQ-022 SHALL on a down-step compute count-1, except at count=0, where the result is MODULUS-1 (SATURATE=0) or stays 0 (SATURATE=1).
REQ-023 SHALL register carry_OutHigh=1 for exactly one cycle after an up-step taken at MODULUS-1, in both modes; otherwise 0.
REQ-024 SHALL register borrow_OutHigh=1 for exactly one cycle after a down-step taken at 0, in both modes; otherwise 0.
REQ-025 SHALL keep count, carry and borrow unchanged on idle edges and non-step edges, apart from carry/borrow returning to 0.
REQ-026 SHALL perform all arithmetic modulo MODULUS, so data_OutBUS never leaves 0..MODULUS-1.
REQ-027 SHALL drive every output directly from a register, with no combinational path from any input.

Reset
REQ-028 SHALL, while RESET_InLow=0, immediately and regardless of clock force count=0, prescaler=0, carry=0 and borrow=0.
REQ-029 SHALL resume normal operation on the first rising clock edge after RESET_InLow deasserts; assertion mid-prescale discards the partial prescale.

Verification
REQ-030 SHALL verify wrap up: W=4, MODULUS=10, SATURATE=0, PRESCALE=1, up held 12 cycles from 0 -> 1..9,0,1,2; carry high one cycle as 9->0.
REQ-031 SHALL verify saturation: SATURATE=1, MODULUS=10, down from 2 held 4 cycles -> 1,0,0,0; borrow pulses once per step taken at 0 (twice).
REQ-032 SHALL verify prescale: PRESCALE=3, up held 9 cycles from 0 -> steps on edges 3,6,9, final value 3; idle for 2 cycles mid-way delays the steps by 2.
REQ-033 SHALL verify priority/clamp: clear, load and up asserted together -> 0; load 0xF with MODULUS=10 -> 9; up and down both asserted -> hold.
REQ-034 SHALL verify reset: async reset asserted between edges at count=7 -> data_OutBUS=0 without a clock edge; first step after deassert -> 1.
